// File: rtl/wb_scr_pkg.sv
// Shared types and helpers for the SCR1 memif to Wishbone classic bridge.
package wb_scr_pkg;

    // Bridge control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Response codes presented on mem_resp_o.
    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ER   = 2'd2
    } resp_e;

    // Command codes on mem_cmd_i.
    typedef enum logic {
        CMD_RD = 1'b0,
        CMD_WR = 1'b1
    } cmd_e;

    // Access width codes on mem_width_i.
    typedef enum logic [1:0] {
        W_BYTE  = 2'd0,
        W_HWORD = 2'd1,
        W_WORD  = 2'd2,
        W_DWORD = 2'd3
    } width_e;

    // Number of address bits that select a byte lane within one bus word.
    function automatic int sel_log2(input int sel_w);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((32'sd1 << i) < sel_w) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_master_scr_bridge_if.sv
// SCR1 memif request/response signals plus the Wishbone master bus.
// Signal names keep the bridge's point of view (_i into the bridge, _o out).
interface wb_master_scr_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    localparam int SEL_W = DW / 8
);
    logic             mem_req_i;
    logic             mem_req_ack_o;
    logic             mem_cmd_i;
    logic [1:0]       mem_width_i;
    logic [AW-1:0]    mem_addr_i;
    logic [DW-1:0]    mem_wdata_i;
    logic [DW-1:0]    mem_rdata_o;
    logic [1:0]       mem_resp_o;
    logic [AW-1:0]    wbm_adr_o;
    logic [DW-1:0]    wbm_dat_o;
    logic [DW-1:0]    wbm_dat_i;
    logic             wbm_we_o;
    logic [SEL_W-1:0] wbm_sel_o;
    logic             wbm_stb_o;
    logic             wbm_cyc_o;
    logic             wbm_ack_i;
    logic             wbm_err_i;

    // Bridge side.
    modport master (
        input  mem_req_i, mem_cmd_i, mem_width_i, mem_addr_i, mem_wdata_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output mem_req_ack_o, mem_rdata_o, mem_resp_o,
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
    );

    // Environment side: the SCR1 core plus the Wishbone slave.
    modport slave (
        output mem_req_i, mem_cmd_i, mem_width_i, mem_addr_i, mem_wdata_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  mem_req_ack_o, mem_rdata_o, mem_resp_o,
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
    );
endinterface

// File: rtl/wb_scr_lane_gen.sv
// Byte-lane steering: turns an access width and in-word offset into byte
// selects, lane-replicated write data and an alignment error flag.
module wb_scr_lane_gen
    import wb_scr_pkg::*;
#(
    parameter int DW = 32,
    localparam int SEL_W = DW / 8,
    localparam int OFFW  = sel_log2(SEL_W)
) (
    input  logic [1:0]       width_i,
    input  logic [OFFW-1:0]  offset_i,
    input  logic [DW-1:0]    wdata_i,
    output logic [SEL_W-1:0] sel_o,
    output logic [DW-1:0]    dat_o,
    output logic             misaligned_o
);

    logic [SEL_W-1:0] base_s;

    // Lane mask at offset zero, replicated data and alignment check per width.
    always_comb begin
        base_s       = '0;
        dat_o        = wdata_i;
        misaligned_o = 1'b0;
        case (width_i)
            W_BYTE: begin
                base_s = SEL_W'(4'h1);
                dat_o  = {SEL_W{wdata_i[7:0]}};
            end
            W_HWORD: begin
                base_s       = SEL_W'(4'h3);
                dat_o        = {(DW/16){wdata_i[15:0]}};
                misaligned_o = offset_i[0];
            end
            W_WORD: begin
                base_s       = SEL_W'(4'hF);
                dat_o        = {(DW/32){wdata_i[31:0]}};
                misaligned_o = |offset_i[1:0];
            end
            W_DWORD: begin
                // A 32-bit bus cannot carry a dword at all.
                base_s       = '1;
                dat_o        = wdata_i;
                misaligned_o = (DW != 32'sd64) || (|offset_i);
            end
            default: begin
                base_s       = '0;
                dat_o        = wdata_i;
                misaligned_o = 1'b1;
            end
        endcase
    end

    assign sel_o = base_s << offset_i;

endmodule

// File: rtl/wb_master_scr_bridge.sv
// SCR1 memif to Wishbone B4 classic master bridge, one access in flight.
// Misaligned requests are answered with an error without touching the bus;
// bus error, ack and the optional timeout all end a bus cycle.
module wb_master_scr_bridge
    import wb_scr_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_master_scr_bridge_if.master bus
);

    localparam int SEL_W = DW / 8;
    localparam int OFFW  = sel_log2(SEL_W);
    localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUS  = ST_BUS;
    localparam logic [1:0] S_RESP = ST_RESP;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             we_q, we_d;
    logic             cyc_q, cyc_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       resp_q, resp_d;
    logic [TW-1:0]    cnt_q, cnt_d;

    logic [SEL_W-1:0] lane_sel_s;
    logic [DW-1:0]    lane_dat_s;
    logic             lane_mis_s;

    wb_scr_lane_gen #(.DW(DW)) u_lane_gen (
        .width_i      (bus.mem_width_i),
        .offset_i     (bus.mem_addr_i[OFFW-1:0]),
        .wdata_i      (bus.mem_wdata_i),
        .sel_o        (lane_sel_s),
        .dat_o        (lane_dat_s),
        .misaligned_o (lane_mis_s)
    );

    // Next-state logic for the FSM, bus registers, response and timeout counter.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                resp_d = RESP_IDLE;
                if (bus.mem_req_i) begin
                    adr_d = {bus.mem_addr_i[AW-1:OFFW], {OFFW{1'b0}}};
                    sel_d = lane_sel_s;
                    dat_d = lane_dat_s;
                    cnt_d = '0;
                    if (lane_mis_s) begin
                        state_d = S_RESP;
                        resp_d  = RESP_ER;
                        we_d    = 1'b0;
                        cyc_d   = 1'b0;
                    end else begin
                        state_d = S_BUS;
                        we_d    = (bus.mem_cmd_i == CMD_WR);
                        cyc_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUS: begin
                if (bus.wbm_err_i) begin
                    resp_d  = RESP_ER;
                    state_d = S_RESP;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (bus.wbm_ack_i) begin
                    if (!we_q) begin
                        rdata_d = bus.wbm_dat_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    resp_d  = RESP_OK;
                    state_d = S_RESP;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    resp_d  = RESP_ER;
                    state_d = S_RESP;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    if (cnt_q != {TW{1'b1}}) begin
                        cnt_d = cnt_q + TW'(1'b1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            S_RESP: begin
                // Response is shown for exactly this one cycle.
                resp_d  = RESP_IDLE;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                resp_d  = RESP_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_req_ack_o = (state_q == S_IDLE) && !wb_rst_i;
    assign bus.mem_rdata_o   = rdata_q;
    assign bus.mem_resp_o    = resp_q;
    assign bus.wbm_adr_o     = adr_q;
    assign bus.wbm_dat_o     = dat_q;
    assign bus.wbm_sel_o     = sel_q;
    assign bus.wbm_we_o      = we_q;
    assign bus.wbm_cyc_o     = cyc_q;
    assign bus.wbm_stb_o     = cyc_q;

endmodule

// File: tb/tb_wb_master_scr_bridge.sv
// Bench for wb_master_scr_bridge: a 32-bit instance with a short timeout and
// a 64-bit instance, a behavioural Wishbone slave and a response scoreboard.
module tb_wb_master_scr_bridge;
    import wb_scr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_master_scr_bridge_if #(.AW(32), .DW(32)) if32 ();
    wb_master_scr_bridge_if #(.AW(32), .DW(64)) if64 ();

    wb_master_scr_bridge #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut32 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (if32.master)
    );

    wb_master_scr_bridge #(.AW(32), .DW(64), .TIMEOUT_CYCLES(255)) dut64 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (if64.master)
    );

    typedef struct {
        logic        is64;
        logic [1:0]  width;
        logic        cmd;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          sl_wait;   // wait states before the slave answers
        int          sl_mode;   // 0 ack, 1 err, 2 ack and err together
        logic [63:0] sl_data;
        logic [7:0]  e_sel;
        logic [63:0] e_dat;
        logic [31:0] e_adr;
        int          e_ncyc;    // cycles with cyc high
        int          e_lat;     // cycles from accept edge to response cycle
        logic [1:0]  e_resp;
        logic [63:0] e_rdata;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [63:0] rdata;
    } exp_t;

    typedef struct {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [7:0]  sel;
        logic [31:0] adr;
        logic [63:0] dat;
        logic [1:0]  resp;
        logic [63:0] rdata;
        logic        req_ack;
    } obs_t;

    exp_t q32[$];
    exp_t q64[$];
    int errors = 0;
    int checks = 0;

    int          sl_wait = 0;
    int          sl_mode = 0;
    logic [63:0] sl_data = 64'h0;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic obs_t observe(input logic is64);
        obs_t o;
        if (is64) begin
            o.cyc = if64.wbm_cyc_o;   o.stb = if64.wbm_stb_o;   o.we = if64.wbm_we_o;
            o.sel = if64.wbm_sel_o;   o.adr = if64.wbm_adr_o;   o.dat = if64.wbm_dat_o;
            o.resp = if64.mem_resp_o; o.rdata = if64.mem_rdata_o; o.req_ack = if64.mem_req_ack_o;
        end else begin
            o.cyc = if32.wbm_cyc_o;   o.stb = if32.wbm_stb_o;   o.we = if32.wbm_we_o;
            o.sel = {4'h0, if32.wbm_sel_o}; o.adr = if32.wbm_adr_o; o.dat = {32'h0, if32.wbm_dat_o};
            o.resp = if32.mem_resp_o; o.rdata = {32'h0, if32.mem_rdata_o}; o.req_ack = if32.mem_req_ack_o;
        end
        return o;
    endfunction

    function automatic vec_t mk(input logic is64, input logic [1:0] w, input logic cmd,
                                input logic [31:0] a, input logic [63:0] wd, input int sw,
                                input int sm, input logic [63:0] sd, input logic [7:0] es,
                                input logic [63:0] ed, input logic [31:0] ea, input int en,
                                input int el, input logic [1:0] er, input logic [63:0] erd);
        vec_t v;
        v.is64 = is64; v.width = w; v.cmd = cmd; v.addr = a; v.wdata = wd;
        v.sl_wait = sw; v.sl_mode = sm; v.sl_data = sd;
        v.e_sel = es; v.e_dat = ed; v.e_adr = ea; v.e_ncyc = en; v.e_lat = el;
        v.e_resp = er; v.e_rdata = erd;
        return v;
    endfunction

    task automatic drive_req(input vec_t v, input logic req);
        if (v.is64) begin
            if64.mem_req_i = req; if64.mem_cmd_i = v.cmd; if64.mem_width_i = v.width;
            if64.mem_addr_i = v.addr; if64.mem_wdata_i = v.wdata;
        end else begin
            if32.mem_req_i = req; if32.mem_cmd_i = v.cmd; if32.mem_width_i = v.width;
            if32.mem_addr_i = v.addr; if32.mem_wdata_i = v.wdata[31:0];
        end
    endtask

    task automatic push_exp(input logic is64, input logic [1:0] resp, input logic [63:0] rdata);
        exp_t e;
        e.resp = resp;
        e.rdata = rdata;
        if (is64) q64.push_back(e);
        else      q32.push_back(e);
    endtask

    // One request through accept, bus cycle and response, timing checked on the way.
    task automatic run_vec(input int idx, input vec_t v);
        obs_t o;
        int ncyc;
        int lat;
        ncyc = 0;
        lat = 0;
        sl_wait = v.sl_wait;
        sl_mode = v.sl_mode;
        sl_data = v.sl_data;
        @(negedge clk);
        drive_req(v, 1'b1);
        o = observe(v.is64);
        chk($sformatf("v%0d req_ack_idle", idx), 64'(o.req_ack), 64'h1);
        @(posedge clk);
        #1;
        drive_req(v, 1'b0);
        push_exp(v.is64, v.e_resp, v.e_rdata);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            o = observe(v.is64);
            if (i == 1) chk($sformatf("v%0d req_ack_busy", idx), 64'(o.req_ack), 64'h0);
            if (o.cyc) begin
                ncyc++;
                if (ncyc == 1) begin
                    chk($sformatf("v%0d adr", idx), 64'(o.adr), 64'(v.e_adr));
                    chk($sformatf("v%0d sel", idx), 64'(o.sel), 64'(v.e_sel));
                    chk($sformatf("v%0d dat", idx), o.dat, v.e_dat);
                    chk($sformatf("v%0d we", idx), 64'(o.we), 64'(v.cmd));
                    chk($sformatf("v%0d stb", idx), 64'(o.stb), 64'h1);
                end
            end
            if (o.resp != 2'd0) begin
                lat = i;
                break;
            end
        end
        chk($sformatf("v%0d cyc_cycles", idx), 64'(ncyc), 64'(v.e_ncyc));
        chk($sformatf("v%0d resp_latency", idx), 64'(lat), 64'(v.e_lat));
        @(negedge clk);
        o = observe(v.is64);
        chk($sformatf("v%0d resp_one_cycle", idx), 64'(o.resp), 64'h0);
        chk($sformatf("v%0d req_ack_again", idx), 64'(o.req_ack), 64'h1);
    endtask

    // Wishbone slave: answers on the (sl_wait+1)-th cycle of cyc.
    initial begin
        int c32;
        int c64;
        logic h;
        c32 = 0;
        c64 = 0;
        if32.wbm_ack_i = 1'b0; if32.wbm_err_i = 1'b0; if32.wbm_dat_i = 32'h0;
        if64.wbm_ack_i = 1'b0; if64.wbm_err_i = 1'b0; if64.wbm_dat_i = 64'h0;
        forever begin
            @(negedge clk);
            if (if32.wbm_cyc_o) c32++; else c32 = 0;
            h = if32.wbm_cyc_o && if32.wbm_stb_o && (c32 == sl_wait + 1);
            if32.wbm_ack_i = h && (sl_mode != 1);
            if32.wbm_err_i = h && (sl_mode != 0);
            if32.wbm_dat_i = sl_data[31:0];
            if (if64.wbm_cyc_o) c64++; else c64 = 0;
            h = if64.wbm_cyc_o && if64.wbm_stb_o && (c64 == sl_wait + 1);
            if64.wbm_ack_i = h && (sl_mode != 1);
            if64.wbm_err_i = h && (sl_mode != 0);
            if64.wbm_dat_i = sl_data;
        end
    end

    // Scoreboard: every non-idle response must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if32.mem_resp_o != 2'd0) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL sb32_unexpected_resp: got resp %0d expected none", if32.mem_resp_o);
                end else begin
                    e = q32.pop_front();
                    checks--;
                    chk("sb32_resp", 64'(if32.mem_resp_o), 64'(e.resp));
                    chk("sb32_rdata", {32'h0, if32.mem_rdata_o}, e.rdata);
                end
            end
            if (if64.mem_resp_o != 2'd0) begin
                checks++;
                if (q64.size() == 0) begin
                    errors++;
                    $display("FAIL sb64_unexpected_resp: got resp %0d expected none", if64.mem_resp_o);
                end else begin
                    e = q64.pop_front();
                    checks--;
                    chk("sb64_resp", 64'(if64.mem_resp_o), 64'(e.resp));
                    chk("sb64_rdata", if64.mem_rdata_o, e.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int first_ack;
        int first_resp;
        vec_t v;

        vecs[0]  = mk(1'b0, 2'd2, 1'b1, 32'h100, 64'hDEADBEEF, 2, 0, 64'h99999999, 8'h0F, 64'hDEADBEEF, 32'h100, 3, 4, 2'd1, 64'h0);
        vecs[1]  = mk(1'b0, 2'd0, 1'b1, 32'h103, 64'h5A, 0, 0, 64'h99999999, 8'h08, 64'h5A5A5A5A, 32'h100, 1, 2, 2'd1, 64'h0);
        vecs[2]  = mk(1'b0, 2'd1, 1'b0, 32'h102, 64'h0, 1, 0, 64'h12345678, 8'h0C, 64'h0, 32'h100, 2, 3, 2'd1, 64'h12345678);
        vecs[3]  = mk(1'b0, 2'd2, 1'b0, 32'h102, 64'h0, 0, 0, 64'h55555555, 8'h00, 64'h0, 32'h0, 0, 1, 2'd2, 64'h12345678);
        vecs[4]  = mk(1'b0, 2'd3, 1'b0, 32'h100, 64'h0, 0, 0, 64'h55555555, 8'h00, 64'h0, 32'h0, 0, 1, 2'd2, 64'h12345678);
        vecs[5]  = mk(1'b0, 2'd2, 1'b0, 32'h200, 64'h0, 0, 2, 64'hCAFEF00D, 8'h0F, 64'h0, 32'h200, 1, 2, 2'd2, 64'h12345678);
        vecs[6]  = mk(1'b0, 2'd2, 1'b0, 32'h204, 64'h0, 1000, 0, 64'h77777777, 8'h0F, 64'h0, 32'h204, 4, 5, 2'd2, 64'h12345678);
        vecs[7]  = mk(1'b0, 2'd1, 1'b1, 32'h106, 64'hBEEF, 0, 0, 64'h99999999, 8'h0C, 64'hBEEFBEEF, 32'h104, 1, 2, 2'd1, 64'h12345678);
        vecs[8]  = mk(1'b0, 2'd2, 1'b0, 32'h300, 64'h0, 1, 1, 64'h66666666, 8'h0F, 64'h0, 32'h300, 2, 3, 2'd2, 64'h12345678);
        vecs[9]  = mk(1'b0, 2'd0, 1'b0, 32'h301, 64'h0, 3, 0, 64'hA1B2C3D4, 8'h02, 64'h0, 32'h300, 4, 5, 2'd1, 64'hA1B2C3D4);
        vecs[10] = mk(1'b0, 2'd1, 1'b1, 32'h101, 64'h1234, 0, 0, 64'h99999999, 8'h00, 64'h0, 32'h0, 0, 1, 2'd2, 64'hA1B2C3D4);
        vecs[11] = mk(1'b1, 2'd0, 1'b1, 32'h105, 64'h77, 0, 0, 64'h9999999999999999, 8'h20, 64'h7777777777777777, 32'h100, 1, 2, 2'd1, 64'h0);
        vecs[12] = mk(1'b1, 2'd3, 1'b1, 32'h108, 64'h0123456789ABCDEF, 1, 0, 64'h9999999999999999, 8'hFF, 64'h0123456789ABCDEF, 32'h108, 2, 3, 2'd1, 64'h0);
        vecs[13] = mk(1'b1, 2'd2, 1'b0, 32'h104, 64'h0, 0, 0, 64'hAAAABBBBCCCCDDDD, 8'hF0, 64'h0, 32'h100, 1, 2, 2'd1, 64'hAAAABBBBCCCCDDDD);
        vecs[14] = mk(1'b1, 2'd3, 1'b0, 32'h104, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0, 32'h0, 0, 1, 2'd2, 64'hAAAABBBBCCCCDDDD);

        // Reset state.
        rst = 1'b1;
        if32.mem_req_i = 1'b0; if32.mem_cmd_i = 1'b0; if32.mem_width_i = 2'd0;
        if32.mem_addr_i = 32'h0; if32.mem_wdata_i = 32'h0;
        if64.mem_req_i = 1'b0; if64.mem_cmd_i = 1'b0; if64.mem_width_i = 2'd0;
        if64.mem_addr_i = 32'h0; if64.mem_wdata_i = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            o = observe(k == 1);
            chk($sformatf("rst%0d cyc", k), 64'(o.cyc), 64'h0);
            chk($sformatf("rst%0d stb_we", k), 64'({o.stb, o.we}), 64'h0);
            chk($sformatf("rst%0d sel_adr", k), 64'({o.sel, o.adr}), 64'h0);
            chk($sformatf("rst%0d dat", k), o.dat, 64'h0);
            chk($sformatf("rst%0d resp", k), 64'(o.resp), 64'h0);
            chk($sformatf("rst%0d rdata", k), o.rdata, 64'h0);
            chk($sformatf("rst%0d req_ack", k), 64'(o.req_ack), 64'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst req_ack32", 64'(if32.mem_req_ack_o), 64'h1);
        chk("post_rst req_ack64", 64'(if64.mem_req_ack_o), 64'h1);

        // Table-driven accesses.
        for (int i = 0; i < 15; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back reads with mem_req_i held high.
        sl_wait = 0; sl_mode = 0; sl_data = 64'h11112222;
        v = mk(1'b0, 2'd2, 1'b0, 32'h400, 64'h0, 0, 0, 64'h0, 8'h0, 64'h0, 32'h0, 0, 0, 2'd0, 64'h0);
        @(negedge clk);
        drive_req(v, 1'b1);
        @(posedge clk);
        #1;
        push_exp(1'b0, 2'd1, 64'h11112222);
        first_ack = 0;
        first_resp = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if32.mem_resp_o != 2'd0 && first_resp == 0) begin
                first_resp = i;
                sl_data = 64'h33334444;
            end
            if (if32.mem_req_ack_o) begin
                first_ack = i;
                break;
            end
        end
        chk("b2b first_resp_cycle", 64'(first_resp), 64'h2);
        chk("b2b second_req_ack_cycle", 64'(first_ack), 64'h3);
        @(posedge clk);
        #1;
        if32.mem_req_i = 1'b0;
        push_exp(1'b0, 2'd1, 64'h33334444);
        first_resp = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if32.mem_resp_o != 2'd0) begin
                first_resp = i;
                break;
            end
        end
        chk("b2b second_resp_cycle", 64'(first_resp), 64'h2);

        // Reset pulsed while a bus cycle is open.
        sl_wait = 1000; sl_mode = 0;
        v = mk(1'b0, 2'd2, 1'b0, 32'h500, 64'h0, 0, 0, 64'h0, 8'h0, 64'h0, 32'h0, 0, 0, 2'd0, 64'h0);
        @(negedge clk);
        drive_req(v, 1'b1);
        @(posedge clk);
        #1;
        drive_req(v, 1'b0);
        @(negedge clk);
        chk("rstmid cyc_c1", 64'(if32.wbm_cyc_o), 64'h1);
        @(negedge clk);
        chk("rstmid cyc_c2", 64'(if32.wbm_cyc_o), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid cyc_stb_after", 64'({if32.wbm_cyc_o, if32.wbm_stb_o}), 64'h0);
        chk("rstmid req_ack_in_rst", 64'(if32.mem_req_ack_o), 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid no_resp_%0d", i), 64'(if32.mem_resp_o), 64'h0);
        end
        chk("rstmid rdata_cleared", 64'(if32.mem_rdata_o), 64'h0);
        chk("rstmid req_ack_back", 64'(if32.mem_req_ack_o), 64'h1);

        chk("sb32 drained", 64'(q32.size()), 64'h0);
        chk("sb64 drained", 64'(q64.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_master_scr_bridge.md
Name: wb_master_scr_bridge

Overview:
Parametrised SCR1 memif to Wishbone B4 classic master bridge. It replaces the single-purpose write-strobe bridge and carries the full SCR1 request/response handshake.
- Supports byte, halfword and word access widths, with byte-lane steering for 32- and 64-bit buses.
- Reports errors for misalignment, bus error and timeout.
- Sits between the SCR1 dmem/imem port and the SoC Wishbone interconnect.
- One outstanding transaction at a time.

Parameters:
AW, 32, address width (memif and Wishbone).
DW, 32, data width; legal values 32 or 64.
TIMEOUT_CYCLES, 255, max cycles waiting for ack/err before aborting; 0 disables the timeout.
SEL_W, DW/8, derived localparam; byte-select width.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, synchronous, active-high
mem_req_i  in  1  request valid
mem_req_ack_o  out  1  request accepted this cycle
mem_cmd_i  in  1  0=read, 1=write
mem_width_i  in  2  0=byte, 1=halfword, 2=word, 3=dword (dword legal only when DW=64)
mem_addr_i  in  AW  byte address
mem_wdata_i  in  DW  write data, right-aligned (LSBs)
mem_rdata_o  out  DW  read data, full bus word, unshifted
mem_resp_o  out  2  0=idle, 1=ready-ok, 2=ready-error
wbm_adr_o  out  AW  address, word-aligned (low log2(SEL_W) bits forced 0)
wbm_dat_o  out  DW  write data, replicated across lanes
wbm_dat_i  in  DW  read data
wbm_we_o  out  1  write enable
wbm_sel_o  out  SEL_W  byte selects
wbm_stb_o  out  1  strobe
wbm_cyc_o  out  1  cycle
wbm_ack_i  in  1  acknowledge
wbm_err_i  in  1  bus error

Behaviour:
- Reset (wb_rst_i=1 at a posedge): all wbm_* outputs 0, mem_rdata_o 0, mem_resp_o idle, state IDLE, timeout counter 0.
- Reset mid-transaction: cyc/stb deassert at that edge; no response is issued; the pending request is lost.
- State machine IDLE, BUS, RESP.
- mem_req_ack_o = 1 iff state==IDLE and wb_rst_i==0. It is combinational from state only and never depends on mem_req_i.
- Accept occurs when mem_req_i && mem_req_ack_o at a posedge.
- On accept, register:
  - adr;
  - we = cmd;
  - sel from width and offset: byte 1 lane, halfword 2 lanes, word 4 lanes, dword all lanes; shifted by addr[log2(SEL_W)-1:0];
  - dat = wdata replicated at the access size across the bus.
- Misalignment: halfword addr[0]!=0, word addr[1:0]!=0, dword addr[2:0]!=0, or dword with DW=32.
  - Go to RESP with error; cyc/stb stay 0 and no bus cycle is issued.
- Aligned accept: go to BUS; cyc=stb=1 from the next cycle; timeout counter cleared.
- BUS, wbm_err_i=1: set resp error, rdata unchanged. Takes priority over a simultaneous ack.
- BUS, wbm_ack_i=1 with no err: latch wbm_dat_i into rdata when we=0; set resp ok.
- BUS, timeout counter == TIMEOUT_CYCLES-1 with no ack/err (and TIMEOUT_CYCLES!=0): resp error.
- Any of the three BUS exits: cyc, stb and we deassert at the same edge, then go to RESP. Otherwise increment the counter (saturating).
- RESP: mem_resp_o is non-idle for exactly one cycle, then returns to idle; go to IDLE. mem_rdata_o holds until the next read completes.
- Latency, aligned access: accept edge T0; cyc/stb high T0+1; ack sampled at edge Tn; resp valid in cycle Tn+1; req_ack high again in cycle Tn+2. Zero-wait-state slave gives 3 cycles per access.
- Misaligned access: resp error in cycle T0+1.
- mem_req_i is ignored outside IDLE.
- wbm_sel_o, wbm_adr_o and wbm_dat_o are stable while cyc=1.

Decomposition:
- Package wb_scr_pkg holds:
  - state enum (IDLE/BUS/RESP);
  - memif resp codes (IDLE/OK/ER), cmd codes (RD/WR), width codes (BYTE/HWORD/WORD/DWORD);
  - helper function for log2 of SEL_W.
- Sub-module wb_scr_lane_gen: combinational; inputs width, addr offset, wdata; outputs sel, replicated data, misaligned flag. Parametrised by DW.
- The top level holds the FSM, timeout counter and registers.

Test Plan:
- DW=32, word write addr 0x100, wdata 0xDEADBEEF, ack after 2 wait states -> adr 0x100, sel 4'hF, dat 0xDEADBEEF, we=1; resp=OK exactly one cycle, 4 cycles after accept.
- Byte write addr 0x103, wdata 0x5A -> sel 4'b1000, dat 0x5A5A5A5A, adr 0x100. Halfword read addr 0x102, slave returns 0x12345678 -> sel 4'b1100, rdata 0x12345678, resp OK.
- Misaligned word read addr 0x102 -> cyc never asserted, resp ER in cycle after accept. DW=32 dword request -> same result.
- Slave asserts ack and err together -> resp ER, rdata unchanged. TIMEOUT_CYCLES=4 with silent slave -> cyc high exactly 4 cycles, then resp ER.
- Back-to-back: mem_req_i held high for two reads -> second req_ack only after the first RESP cycle. wb_rst_i pulsed while cyc=1 -> cyc/stb 0 next cycle, no resp emitted.
- DW=64, byte write addr 0x...5 -> sel 8'b00100000; dword write addr 0x...8 -> sel 8'hFF.
